arcade_input_cond: RTL and testbench

// Conditions raw player controls before they reach the game core's INP0/INP1 input bytes.
// - Raw sources: ps2 key flags OR'd with hps joystick bits.
// - Synchronises and debounces every control bit.
// - Reshapes each coin input into a frame-locked pulse of fixed length, followed by a

---
 rtl/arcade_input_cond.sv | 162 ++++++++++++++++
 tb/tb_arcade_input_cond.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_cond.sv
// Player control conditioning: sync, debounce and frame-locked coin pulse shaping.
// Feeds the game core's INP0/INP1 input bytes.
module arcade_input_cond #(
    parameter int NBTN            = 16,
    parameter int DEB_CYCLES      = 48000,
    parameter int COIN_FRAMES     = 4,
    parameter int COIN_GAP_FRAMES = 4
) (
    input  logic            clk_sys,
    input  logic            RESET_N,
    input  logic            VBLK,
    input  logic [NBTN-1:0] RAW_IN,
    input  logic [1:0]      COIN_IN,
    output logic [NBTN-1:0] DEB_OUT,
    output logic [1:0]      COIN_OUT,
    output logic [1:0]      COIN_BUSY
);

    localparam int NB   = NBTN + 2;
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int FMAX = (COIN_FRAMES > COIN_GAP_FRAMES) ?
                          COIN_FRAMES : COIN_GAP_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(COIN_FRAMES - 1);
    localparam logic [FW-1:0] G_LAST   = FW'(COIN_GAP_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PULSE,
        GAP
    } coin_st_t;

    logic [NB-1:0] sync1, sync2, deb;
    logic [2:0]    vs;
    logic [1:0]    coin_q;
    logic [1:0]    coin_edge;
    logic          tick;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1  <= '0;
            sync2  <= '0;
            vs     <= '0;
            coin_q <= '0;
        end else begin
            sync1  <= {COIN_IN, RAW_IN};
            sync2  <= sync1;
            vs     <= {vs[1:0], VBLK};
            coin_q <= deb[NB-1:NBTN];
        end
    end

    assign tick      = vs[1] & ~vs[2];
    assign coin_edge = deb[NB-1:NBTN] & ~coin_q;
    assign DEB_OUT   = deb[NBTN-1:0];

    for (genvar g = 0; g < NB; g++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          d;

        // Counts consecutive cycles the synced input disagrees with the output
        always_ff @(posedge clk_sys or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt <= '0;
                d   <= 1'b0;
            end else if (sync2[g] == d) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt <= '0;
                d   <= sync2[g];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[g] = d;
    end

    for (genvar c = 0; c < 2; c++) begin : g_coin
        coin_st_t      state_q, state_d;
        logic [FW-1:0] fcnt_q, fcnt_d;
        logic          pend_q, pend_d;
        logic          out_q, out_d;
        logic          busy_q, busy_d;

        always_ff @(posedge clk_sys or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q <= IDLE;
                fcnt_q  <= '0;
                pend_q  <= 1'b0;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                fcnt_q  <= fcnt_d;
                pend_q  <= pend_d;
                out_q   <= out_d;
                busy_q  <= busy_d;
            end
        end

        always_comb begin
            state_d = state_q;
            fcnt_d  = fcnt_q;
            pend_d  = pend_q;
            out_d   = out_q;
            unique case (state_q)
                IDLE: begin
                    if (coin_edge[c]) begin
                        state_d = ARM;
                        fcnt_d  = '0;
                    end
                end
                ARM: begin
                    if (coin_edge[c]) pend_d = 1'b1;
                    if (tick) begin
                        state_d = PULSE;
                        fcnt_d  = '0;
                        out_d   = 1'b1;
                    end
                end
                PULSE: begin
                    if (coin_edge[c]) pend_d = 1'b1;
                    if (tick && fcnt_q == F_LAST) begin
                        state_d = GAP;
                        fcnt_d  = '0;
                        out_d   = 1'b0;
                    end else if (tick) begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (coin_edge[c]) pend_d = 1'b1;
                    if (tick && fcnt_q == G_LAST) begin
                        fcnt_d = '0;
                        // A queued coin is consumed; an edge this cycle becomes the new queue
                        if (pend_q) begin
                            state_d = ARM;
                            pend_d  = coin_edge[c];
                        end else if (coin_edge[c]) begin
                            state_d = ARM;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (tick) begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            busy_d = (state_d != IDLE) | pend_d;
        end

        assign COIN_OUT[c]  = out_q;
        assign COIN_BUSY[c] = busy_q;
    end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Randomised and directed bench for arcade_input_cond against a
// coin-timeline reference model.
module tb_arcade_input_cond;

    localparam int NBTN = 4;
    localparam int DEB  = 8;
    localparam int FR   = 4;
    localparam int GP   = 4;
    localparam int NB   = NBTN + 2;

    logic            clk_sys = 1'b0;
    logic            RESET_N = 1'b0;
    logic            VBLK    = 1'b0;
    logic [NBTN-1:0] RAW_IN  = '0;
    logic [1:0]      COIN_IN = '0;
    logic [NBTN-1:0] DEB_OUT;
    logic [1:0]      COIN_OUT;
    logic [1:0]      COIN_BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    arcade_input_cond #(
        .NBTN(NBTN),
        .DEB_CYCLES(DEB),
        .COIN_FRAMES(FR),
        .COIN_GAP_FRAMES(GP)
    ) dut (
        .clk_sys(clk_sys),
        .RESET_N(RESET_N),
        .VBLK(VBLK),
        .RAW_IN(RAW_IN),
        .COIN_IN(COIN_IN),
        .DEB_OUT(DEB_OUT),
        .COIN_OUT(COIN_OUT),
        .COIN_BUSY(COIN_BUSY)
    );

    always #5 clk_sys = ~clk_sys;

    bit vblk_run = 1'b1;
    int vcyc = 0;
    always @(negedge clk_sys) begin
        if (vblk_run) begin
            vcyc = (vcyc + 1) % 100;
            VBLK = (vcyc < 50);
        end
    end

    // Reference model: inputs seen two edges late, a level accepted after
    // DEB steady samples, coins served as a timeline counted in frame ticks.
    bit [NB-1:0] m_s1, m_s2, m_deb;
    int          m_run [NB];
    bit          m_v1, m_v2, m_v3;
    bit [1:0]    m_cprev, m_active, m_queued, m_out, m_busy;
    int          m_phase [2];

    always @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            m_v1 = 0; m_v2 = 0; m_v3 = 0;
            m_cprev = '0; m_active = '0; m_queued = '0;
            m_out = '0; m_busy = '0;
            for (int b = 0; b < NB; b++) m_run[b] = 0;
            for (int c = 0; c < 2; c++) m_phase[c] = 0;
        end else begin
            bit tk;
            bit ce;
            tk = m_v2 & ~m_v3;
            for (int c = 0; c < 2; c++) begin
                ce = m_deb[NBTN+c] & ~m_cprev[c];
                if (m_active[c] && tk) begin
                    m_phase[c]++;
                    if (m_phase[c] == 1 + FR + GP) begin
                        if (m_queued[c]) begin
                            m_phase[c]  = 0;
                            m_queued[c] = 0;
                        end else begin
                            m_active[c] = 0;
                        end
                    end
                end
                if (ce) begin
                    if (!m_active[c]) begin
                        m_active[c] = 1;
                        m_phase[c]  = 0;
                    end else begin
                        m_queued[c] = 1;
                    end
                end
                m_out[c]  = m_active[c] && m_phase[c] >= 1 && m_phase[c] <= FR;
                m_busy[c] = m_active[c] | m_queued[c];
                m_cprev[c] = m_deb[NBTN+c];
            end
            for (int b = 0; b < NB; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_deb[b] = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_v3 = m_v2; m_v2 = m_v1; m_v1 = VBLK;
            m_s2 = m_s1; m_s1 = {COIN_IN, RAW_IN};
        end
    end

    function automatic logic [7:0] exp_vec();
        return {m_deb[NBTN-1:0], m_out, m_busy};
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_cmp++;
        if (DEB_OUT !== 4'h0) begin
            n_bad++; $display("FAIL reset_deb got=%h want=0", DEB_OUT);
        end
        n_cmp++;
        if (COIN_OUT !== 2'b00) begin
            n_bad++; $display("FAIL reset_coin got=%b want=00", COIN_OUT);
        end
        n_cmp++;
        if (COIN_BUSY !== 2'b00) begin
            n_bad++; $display("FAIL reset_busy got=%b want=00", COIN_BUSY);
        end
        RESET_N = 1'b1;
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic test_glitch();
        RAW_IN[3] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_sys);
            if (i == 6) RAW_IN[3] = 1'b0;
            n_cmp++;
            if (DEB_OUT[3] !== 1'b0 || {DEB_OUT, COIN_OUT, COIN_BUSY} !== exp_vec()) begin
                n_bad++;
                $display("FAIL glitch cyc=%0d got=%h want=%h",
                         i, {DEB_OUT, COIN_OUT, COIN_BUSY}, exp_vec());
            end
        end
    endtask

    task automatic test_deb_latency();
        int rise = -1;
        int fall = -1;
        @(negedge clk_sys);
        RAW_IN[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_sys); #1;
            if (DEB_OUT[1] === 1'b1 && rise < 0) rise = i;
        end
        n_cmp++;
        if (rise != 10) begin
            n_bad++; $display("FAIL deb_rise got=%0d want=10", rise);
        end
        @(negedge clk_sys);
        RAW_IN[1] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_sys); #1;
            if (DEB_OUT[1] === 1'b0 && fall < 0) fall = i;
        end
        n_cmp++;
        if (fall != 10) begin
            n_bad++; $display("FAIL deb_fall got=%0d want=10", fall);
        end
    endtask

    task automatic test_coin_single();
        int rise_at = -1;
        int fall_at = -1;
        int pulses = 0;
        bit prev = 0;
        COIN_IN[0] = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk_sys);
            if (i == 19) COIN_IN[0] = 1'b0;
            n_cmp++;
            if ({DEB_OUT, COIN_OUT, COIN_BUSY} !== exp_vec()) begin
                n_bad++;
                $display("FAIL single_model cyc=%0d got=%h want=%h",
                         i, {DEB_OUT, COIN_OUT, COIN_BUSY}, exp_vec());
            end
            if (COIN_OUT[0] && !prev) begin pulses++; rise_at = i; end
            if (!COIN_OUT[0] && prev) fall_at = i;
            prev = COIN_OUT[0];
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++; $display("FAIL single_pulses got=%0d want=1", pulses);
        end
        n_cmp++;
        if (fall_at - rise_at != FR * 100) begin
            n_bad++; $display("FAIL single_width got=%0d want=%0d", fall_at - rise_at, FR * 100);
        end
        n_cmp++;
        if (COIN_BUSY[0] !== 1'b0) begin
            n_bad++; $display("FAIL single_busy got=%b want=0", COIN_BUSY[0]);
        end
    endtask

    task automatic test_coin_queue();
        int pulses = 0;
        int fall_at = -1;
        int gap = -1;
        bit prev = 1;
        bit seen = 0;
        COIN_IN[0] = 1'b1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_sys);
            if (i == 14) COIN_IN[0] = 1'b0;
            if (COIN_OUT[0]) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL queue_start got=0 want=1 (timeout)");
        end
        pulses = seen ? 1 : 0;
        for (int i = 0; i < 2000; i++) begin
            COIN_IN[0] = (i < 90) && ((i % 30) < 12);
            @(negedge clk_sys);
            n_cmp++;
            if ({DEB_OUT, COIN_OUT, COIN_BUSY} !== exp_vec()) begin
                n_bad++;
                $display("FAIL queue_model cyc=%0d got=%h want=%h",
                         i, {DEB_OUT, COIN_OUT, COIN_BUSY}, exp_vec());
            end
            if (COIN_OUT[0] && !prev) begin
                pulses++;
                if (fall_at >= 0 && gap < 0) gap = i - fall_at;
            end
            if (!COIN_OUT[0] && prev && fall_at < 0) fall_at = i;
            prev = COIN_OUT[0];
        end
        COIN_IN[0] = 1'b0;
        n_cmp++;
        if (pulses != 2) begin
            n_bad++; $display("FAIL queue_pulses got=%0d want=2", pulses);
        end
        n_cmp++;
        if (gap < GP * 100) begin
            n_bad++; $display("FAIL queue_gap got=%0d want>=%0d", gap, GP * 100);
        end
        n_cmp++;
        if (COIN_BUSY[0] !== 1'b0) begin
            n_bad++; $display("FAIL queue_busy got=%b want=0", COIN_BUSY[0]);
        end
    endtask

    task automatic test_coin_hold();
        int p0 = 0;
        int p1 = 0;
        bit q0 = 0;
        bit q1 = 0;
        COIN_IN = 2'b11;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk_sys);
            if (i == 1999) COIN_IN = 2'b00;
            n_cmp++;
            if (COIN_OUT[0] !== COIN_OUT[1] ||
                {DEB_OUT, COIN_OUT, COIN_BUSY} !== exp_vec()) begin
                n_bad++;
                $display("FAIL hold_model cyc=%0d got=%h want=%h",
                         i, {DEB_OUT, COIN_OUT, COIN_BUSY}, exp_vec());
            end
            if (COIN_OUT[0] && !q0) p0++;
            if (COIN_OUT[1] && !q1) p1++;
            q0 = COIN_OUT[0];
            q1 = COIN_OUT[1];
        end
        n_cmp++;
        if (p0 != 1 || p1 != 1) begin
            n_bad++; $display("FAIL hold_pulses got=%0d/%0d want=1/1", p0, p1);
        end
    endtask

    task automatic test_vblk_stuck();
        @(negedge clk_sys);
        vblk_run = 1'b0;
        VBLK = 1'b0;
        COIN_IN[1] = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_sys);
            if (i == 19) COIN_IN[1] = 1'b0;
        end
        n_cmp++;
        if (COIN_BUSY[1] !== 1'b1 || COIN_OUT[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_arm got=busy%b/out%b want=busy1/out0", COIN_BUSY[1], COIN_OUT[1]);
        end
        vblk_run = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk_sys);
            n_cmp++;
            if ({DEB_OUT, COIN_OUT, COIN_BUSY} !== exp_vec()) begin
                n_bad++;
                $display("FAIL stuck_model cyc=%0d got=%h want=%h",
                         i, {DEB_OUT, COIN_OUT, COIN_BUSY}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit seen = 0;
        COIN_IN[0] = 1'b1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_sys);
            if (i == 19) COIN_IN[0] = 1'b0;
            if (COIN_OUT[0]) seen = 1;
        end
        COIN_IN[0] = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL rst_start got=0 want=1 (timeout)");
        end
        repeat (50) @(negedge clk_sys);
        RESET_N = 1'b0;
        #1;
        n_cmp++;
        if (COIN_OUT !== 2'b00 || COIN_BUSY !== 2'b00) begin
            n_bad++; $display("FAIL rst_async got=%b/%b want=00/00", COIN_OUT, COIN_BUSY);
        end
        repeat (3) @(negedge clk_sys);
        RESET_N = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            n_cmp++;
            if (COIN_OUT !== 2'b00 || {DEB_OUT, COIN_OUT, COIN_BUSY} !== exp_vec()) begin
                n_bad++;
                $display("FAIL rst_after cyc=%0d got=%h want=%h",
                         i, {DEB_OUT, COIN_OUT, COIN_BUSY}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_sys);
            n_cmp++;
            if ({DEB_OUT, COIN_OUT, COIN_BUSY} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h want=%h",
                         i, {DEB_OUT, COIN_OUT, COIN_BUSY}, exp_vec());
            end
            if ($urandom_range(0, 15) == 0) begin
                int b;
                b = $urandom_range(0, NB - 1);
                if (b < NBTN) RAW_IN[b] = ~RAW_IN[b];
                else COIN_IN[b-NBTN] = ~COIN_IN[b-NBTN];
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_deb_latency();
        test_coin_single();
        test_coin_queue();
        test_coin_hold();
        test_vblk_stuck();
        test_reset_mid_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
